// File: rtl/wei_buf_rsp_if.sv
// Bundles the weight buffer responder's handshake signals into one interface.
//   Config channel : TOPWBF_CfgVld/CfgNum in, WBFTOP_CfgRdy out
//   Fill channel   : GLBWBF_DatVld/Dat in, WBFGLB_DatRdy out
//   Read address   : WCAWBF_AdrVld/Adr in, WBFWCA_AdrRdy out
//   Read data      : WBFWCA_DatVld/Dat out, WCAWBF_DatRdy in
//   Error          : WBFTOP_RdErr out (pulse on out-of-range read)
// The slave modport is the responder; the master modport is everything around it.
interface wei_buf_rsp_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int WEI_ADDR_WIDTH = 8
);
    logic                      TOPWBF_CfgVld;
    logic [WEI_ADDR_WIDTH:0]   TOPWBF_CfgNum;
    logic                      WBFTOP_CfgRdy;
    logic                      GLBWBF_DatVld;
    logic [DATA_WIDTH-1:0]     GLBWBF_Dat;
    logic                      WBFGLB_DatRdy;
    logic                      WCAWBF_AdrVld;
    logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr;
    logic                      WBFWCA_AdrRdy;
    logic                      WBFWCA_DatVld;
    logic [DATA_WIDTH-1:0]     WBFWCA_Dat;
    logic                      WCAWBF_DatRdy;
    logic                      WBFTOP_RdErr;

    modport slave (
        input  TOPWBF_CfgVld, TOPWBF_CfgNum, GLBWBF_DatVld, GLBWBF_Dat,
               WCAWBF_AdrVld, WCAWBF_Adr, WCAWBF_DatRdy,
        output WBFTOP_CfgRdy, WBFGLB_DatRdy, WBFWCA_AdrRdy, WBFWCA_DatVld,
               WBFWCA_Dat, WBFTOP_RdErr
    );

    modport master (
        output TOPWBF_CfgVld, TOPWBF_CfgNum, GLBWBF_DatVld, GLBWBF_Dat,
               WCAWBF_AdrVld, WCAWBF_Adr, WCAWBF_DatRdy,
        input  WBFTOP_CfgRdy, WBFGLB_DatRdy, WBFWCA_AdrRdy, WBFWCA_DatVld,
               WBFWCA_Dat, WBFTOP_RdErr
    );
endinterface

// File: rtl/wei_buf_rsp.sv
// Weight buffer read responder. Filled sequentially from the global buffer,
// then answers single-word reads from the weight cache with one read in flight
// and a fixed one-cycle address-to-data latency.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wei_buf_rsp_if.slave (config, fill, read address/data, error)
//   WBFTOP_RdCnt [15:0] : accepted reads since last config start, saturating
//                         (present only when WBF_STAT_EN is defined)
//
// state | meaning
// IDLE  | waiting for a config strobe; CfgRdy high
// CFG   | one cycle after latching cfg_num; picks FILL or WORK
// FILL  | accepting fill words into mem[wr_ptr]
// WORK  | serving reads; config strobe returns to IDLE
module wei_buf_rsp #(
    parameter int DATA_WIDTH     = 8,
    parameter int WEI_ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    wei_buf_rsp_if.slave        bus
`ifdef WBF_STAT_EN
    ,
    output logic [15:0]         WBFTOP_RdCnt
`endif
);
    localparam int DEPTH = 2 ** WEI_ADDR_WIDTH;
    localparam logic [WEI_ADDR_WIDTH:0] PTR_ONE = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_FILL, ST_WORK} state_t;

    state_t                    state_q, state_d;
    logic [WEI_ADDR_WIDTH:0]   cfg_num_q, cfg_num_d;
    logic [WEI_ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic                      dat_vld_q, dat_vld_d;
    logic [DATA_WIDTH-1:0]     dat_reg_q, dat_reg_d;
    logic                      rd_err_q, rd_err_d;
    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];

    logic                      glb_hs;
    logic                      adr_hs;
    logic                      adr_in_range;
    logic [WEI_ADDR_WIDTH:0]   adr_ext;

    assign bus.WBFTOP_CfgRdy = (state_q == ST_IDLE);
    assign bus.WBFGLB_DatRdy = (state_q == ST_FILL);
    assign bus.WBFWCA_AdrRdy = (state_q == ST_WORK) & (~dat_vld_q | bus.WCAWBF_DatRdy);
    assign bus.WBFWCA_DatVld = dat_vld_q;
    assign bus.WBFWCA_Dat    = dat_vld_q ? dat_reg_q : '0;
    assign bus.WBFTOP_RdErr  = rd_err_q;

    assign glb_hs       = (state_q == ST_FILL) & bus.GLBWBF_DatVld;
    assign adr_hs       = bus.WCAWBF_AdrVld & bus.WBFWCA_AdrRdy;
    assign adr_ext      = {1'b0, bus.WCAWBF_Adr};
    assign adr_in_range = (adr_ext < cfg_num_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cfg_num_q <= '0;
            wr_ptr_q  <= '0;
            dat_vld_q <= 1'b0;
            dat_reg_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_num_q <= cfg_num_d;
            wr_ptr_q  <= wr_ptr_d;
            dat_vld_q <= dat_vld_d;
            dat_reg_q <= dat_reg_d;
            rd_err_q  <= rd_err_d;
        end
    end

    // Storage is deliberately not reset; only written words are ever returned.
    always_ff @(posedge clk) begin
        if (glb_hs) begin
            mem_q[wr_ptr_q[WEI_ADDR_WIDTH-1:0]] <= bus.GLBWBF_Dat;
        end
    end

    always_comb begin
        state_d   = state_q;
        cfg_num_d = cfg_num_q;
        wr_ptr_d  = wr_ptr_q;
        dat_vld_d = dat_vld_q;
        dat_reg_d = dat_reg_q;
        rd_err_d  = 1'b0;

        // A new address wins over a consume, so back-to-back reads keep dat_vld high.
        if (adr_hs) begin
            dat_vld_d = 1'b1;
            dat_reg_d = adr_in_range ? mem_q[bus.WCAWBF_Adr] : '0;
            rd_err_d  = ~adr_in_range;
        end else if (bus.WCAWBF_DatRdy) begin
            dat_vld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.TOPWBF_CfgVld) begin
                    state_d   = ST_CFG;
                    cfg_num_d = bus.TOPWBF_CfgNum;
                    wr_ptr_d  = '0;
                end
            end
            ST_CFG: begin
                state_d = (cfg_num_q == '0) ? ST_WORK : ST_FILL;
            end
            ST_FILL: begin
                if (glb_hs) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (wr_ptr_q == cfg_num_q - PTR_ONE) begin
                        state_d = ST_WORK;
                    end
                end
            end
            ST_WORK: begin
                // Leaving for IDLE drops any pending read and its error flag.
                if (bus.TOPWBF_CfgVld) begin
                    state_d   = ST_IDLE;
                    cfg_num_d = '0;
                    dat_vld_d = 1'b0;
                    rd_err_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef WBF_STAT_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if ((state_q == ST_IDLE) && bus.TOPWBF_CfgVld) begin
            rd_cnt_d = '0;
        end else if (adr_hs && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
    end

    assign WBFTOP_RdCnt = rd_cnt_q;
`endif
endmodule

// File: tb/tb_wei_buf_rsp.sv
module tb_wei_buf_rsp;
    localparam int DW = 8;
    localparam int AW = 8;

    typedef struct {
        logic [DW-1:0] dat;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wei_buf_rsp_if #(.DATA_WIDTH(DW), .WEI_ADDR_WIDTH(AW)) bus ();

`ifdef WBF_STAT_EN
    logic [15:0] rd_cnt;
`endif

    wei_buf_rsp #(.DATA_WIDTH(DW), .WEI_ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef WBF_STAT_EN
        ,
        .WBFTOP_RdCnt (rd_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    exp_t          sb_q[$];
    exp_t          mon_e;
    logic          chk_pending = 1'b0;
    logic [DW-1:0] model [2**AW];
    int            model_num = 0;
    logic [DW-1:0] tab4 [4] = '{8'd11, 8'd22, 8'd33, 8'd44};

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Data for a handshake sampled on one falling edge must appear on the next.
    always @(negedge clk) begin
        if (chk_pending) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow: read data appeared with no expectation queued");
            end else begin
                mon_e = sb_q.pop_front();
                if (bus.WBFWCA_DatVld !== 1'b1 || bus.WBFWCA_Dat !== mon_e.dat ||
                    bus.WBFTOP_RdErr !== mon_e.err) begin
                    failures++;
                    $display("FAIL rd_data: got vld=%b dat=%0d err=%b, expected vld=1 dat=%0d err=%b",
                             bus.WBFWCA_DatVld, bus.WBFWCA_Dat, bus.WBFTOP_RdErr, mon_e.dat, mon_e.err);
                end
            end
        end
        chk_pending = rst_n && bus.WCAWBF_AdrVld && bus.WBFWCA_AdrRdy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input int adr);
        exp_t e;
        e.err = (adr >= model_num);
        e.dat = e.err ? '0 : model[adr];
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.TOPWBF_CfgVld = 1'b0;
        bus.TOPWBF_CfgNum = '0;
        bus.GLBWBF_DatVld = 1'b0;
        bus.GLBWBF_Dat    = '0;
        bus.WCAWBF_AdrVld = 1'b0;
        bus.WCAWBF_Adr    = '0;
        bus.WCAWBF_DatRdy = 1'b0;
        #23;
        checks++;
        if (bus.WBFTOP_CfgRdy !== 1'b1 || bus.WBFGLB_DatRdy !== 1'b0 || bus.WBFWCA_AdrRdy !== 1'b0 ||
            bus.WBFWCA_DatVld !== 1'b0 || bus.WBFWCA_Dat !== '0 || bus.WBFTOP_RdErr !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: cfgrdy=%b glbrdy=%b adrrdy=%b datvld=%b dat=%0d err=%b, expected 1 0 0 0 0 0",
                     bus.WBFTOP_CfgRdy, bus.WBFGLB_DatRdy, bus.WBFWCA_AdrRdy,
                     bus.WBFWCA_DatVld, bus.WBFWCA_Dat, bus.WBFTOP_RdErr);
        end
`ifdef WBF_STAT_EN
        checks++;
        if (rd_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_rdcnt: got %0d expected 0", rd_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic configure(input int num);
        int n = 0;
        while (bus.WBFTOP_CfgRdy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL cfg_wait: CfgRdy=%b after %0d cycles, expected 1", bus.WBFTOP_CfgRdy, n);
        end
        bus.TOPWBF_CfgVld = 1'b1;
        bus.TOPWBF_CfgNum = (AW + 1)'(num);
        tick();
        bus.TOPWBF_CfgVld = 1'b0;
        model_num = num;
        @(negedge clk);
        checks++;
        if (bus.WBFTOP_CfgRdy !== 1'b0 || bus.WBFGLB_DatRdy !== 1'b0 || bus.WBFWCA_AdrRdy !== 1'b0) begin
            failures++;
            $display("FAIL cfg_state: cfgrdy=%b glbrdy=%b adrrdy=%b, expected 0 0 0",
                     bus.WBFTOP_CfgRdy, bus.WBFGLB_DatRdy, bus.WBFWCA_AdrRdy);
        end
    endtask

    task automatic fill(input int num, input int mode);
        int n;
        for (int i = 0; i < num; i++) begin
            bus.GLBWBF_DatVld = 1'b1;
            bus.GLBWBF_Dat    = (mode == 0) ? tab4[i] : (8'(i) ^ 8'h5A);
            model[i]          = bus.GLBWBF_Dat;
            // A config strobe in the middle of a fill must be ignored.
            bus.TOPWBF_CfgVld = (mode == 1 && i == 10);
            n = 0;
            @(negedge clk);
            while (bus.WBFGLB_DatRdy !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                checks++;
                failures++;
                $display("FAIL fill_wait: DatRdy=%b at word %0d, expected 1", bus.WBFGLB_DatRdy, i);
                bus.GLBWBF_DatVld = 1'b0;
                bus.TOPWBF_CfgVld = 1'b0;
                return;
            end
            tick();
        end
        bus.GLBWBF_DatVld = 1'b0;
        bus.TOPWBF_CfgVld = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.WBFWCA_AdrRdy !== 1'b1 || bus.WBFGLB_DatRdy !== 1'b0 || bus.WBFTOP_CfgRdy !== 1'b0) begin
            failures++;
            $display("FAIL fill_done: adrrdy=%b glbrdy=%b cfgrdy=%b, expected 1 0 0",
                     bus.WBFWCA_AdrRdy, bus.WBFGLB_DatRdy, bus.WBFTOP_CfgRdy);
        end
    endtask

    task automatic abort_to_idle();
        bus.TOPWBF_CfgVld = 1'b1;
        tick();
        bus.TOPWBF_CfgVld = 1'b0;
    endtask

    task automatic test_fill_read();
        configure(4);
        fill(4, 0);
        bus.WCAWBF_DatRdy = 1'b1;
        bus.WCAWBF_AdrVld = 1'b1;
        bus.WCAWBF_Adr    = 8'd2;
        push_read(2);
        tick();
        bus.WCAWBF_AdrVld = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (bus.WBFWCA_DatVld !== 1'b0 || bus.WBFWCA_Dat !== '0) begin
            failures++;
            $display("FAIL consume_clear: datvld=%b dat=%0d, expected 0 0", bus.WBFWCA_DatVld, bus.WBFWCA_Dat);
        end
    endtask

    task automatic test_back_to_back();
        int adrs[3] = '{0, 1, 3};
        tick();
        bus.WCAWBF_DatRdy = 1'b1;
        foreach (adrs[i]) begin
            bus.WCAWBF_AdrVld = 1'b1;
            bus.WCAWBF_Adr    = 8'(adrs[i]);
            push_read(adrs[i]);
            @(negedge clk);
            checks++;
            if (bus.WBFWCA_AdrRdy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_adrrdy: got %b at read %0d, expected 1", bus.WBFWCA_AdrRdy, i);
            end
            tick();
        end
        bus.WCAWBF_AdrVld = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_hold();
        bus.WCAWBF_DatRdy = 1'b0;
        bus.WCAWBF_AdrVld = 1'b1;
        bus.WCAWBF_Adr    = 8'd1;
        push_read(1);
        tick();
        bus.WCAWBF_Adr = 8'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.WBFWCA_DatVld !== 1'b1 || bus.WBFWCA_Dat !== 8'd22 || bus.WBFWCA_AdrRdy !== 1'b0) begin
                failures++;
                $display("FAIL hold: cycle %0d datvld=%b dat=%0d adrrdy=%b, expected 1 22 0",
                         c, bus.WBFWCA_DatVld, bus.WBFWCA_Dat, bus.WBFWCA_AdrRdy);
            end
            tick();
        end
        bus.WCAWBF_DatRdy = 1'b1;
        push_read(3);
        #1;
        checks++;
        if (bus.WBFWCA_AdrRdy !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: adrrdy=%b, expected 1", bus.WBFWCA_AdrRdy);
        end
        tick();
        bus.WCAWBF_AdrVld = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_out_of_range();
        bus.WCAWBF_DatRdy = 1'b1;
        bus.WCAWBF_AdrVld = 1'b1;
        bus.WCAWBF_Adr    = 8'd7;
        push_read(7);
        tick();
        bus.WCAWBF_AdrVld = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (bus.WBFTOP_RdErr !== 1'b0 || bus.WBFWCA_DatVld !== 1'b0) begin
            failures++;
            $display("FAIL rderr_pulse: err=%b datvld=%b one cycle later, expected 0 0",
                     bus.WBFTOP_RdErr, bus.WBFWCA_DatVld);
        end
        tick();
    endtask

    task automatic test_abort();
        bus.WCAWBF_DatRdy = 1'b0;
        bus.WCAWBF_AdrVld = 1'b1;
        bus.WCAWBF_Adr    = 8'd2;
        push_read(2);
        tick();
        bus.WCAWBF_AdrVld = 1'b0;
        @(negedge clk);
        abort_to_idle();
        @(negedge clk);
        checks++;
        if (bus.WBFTOP_CfgRdy !== 1'b1 || bus.WBFWCA_DatVld !== 1'b0 || bus.WBFWCA_Dat !== '0 ||
            bus.WBFWCA_AdrRdy !== 1'b0) begin
            failures++;
            $display("FAIL abort: cfgrdy=%b datvld=%b dat=%0d adrrdy=%b, expected 1 0 0 0",
                     bus.WBFTOP_CfgRdy, bus.WBFWCA_DatVld, bus.WBFWCA_Dat, bus.WBFWCA_AdrRdy);
        end
`ifdef WBF_STAT_EN
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (rd_cnt !== 16'd8) begin
            failures++;
            $display("FAIL rdcnt_held: got %0d expected 8", rd_cnt);
        end
`endif
        bus.WCAWBF_DatRdy = 1'b1;
        tick();
    endtask

    task automatic test_cfg_zero();
        configure(0);
`ifdef WBF_STAT_EN
        checks++;
        if (rd_cnt !== 16'd0) begin
            failures++;
            $display("FAIL rdcnt_clear: got %0d expected 0", rd_cnt);
        end
`endif
        tick();
        @(negedge clk);
        checks++;
        if (bus.WBFWCA_AdrRdy !== 1'b1 || bus.WBFGLB_DatRdy !== 1'b0) begin
            failures++;
            $display("FAIL cfg0_work: adrrdy=%b glbrdy=%b, expected 1 0", bus.WBFWCA_AdrRdy, bus.WBFGLB_DatRdy);
        end
        tick();
        bus.WCAWBF_DatRdy = 1'b1;
        bus.WCAWBF_AdrVld = 1'b1;
        bus.WCAWBF_Adr    = 8'd0;
        push_read(0);
        tick();
        bus.WCAWBF_Adr = 8'd255;
        push_read(255);
        tick();
        bus.WCAWBF_AdrVld = 1'b0;
        @(negedge clk);
        tick();
        abort_to_idle();
    endtask

    task automatic test_full_depth();
        int adrs[3] = '{0, 128, 255};
        configure(256);
        fill(256, 1);
        bus.WCAWBF_DatRdy = 1'b1;
        foreach (adrs[i]) begin
            bus.WCAWBF_AdrVld = 1'b1;
            bus.WCAWBF_Adr    = 8'(adrs[i]);
            push_read(adrs[i]);
            tick();
        end
        bus.WCAWBF_AdrVld = 1'b0;
        @(negedge clk);
        tick();
`ifdef WBF_STAT_EN
        checks++;
        if (rd_cnt !== 16'd3) begin
            failures++;
            $display("FAIL rdcnt_full: got %0d expected 3", rd_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_back_to_back();
        test_hold();
        test_out_of_range();
        test_abort();
        test_cfg_zero();
        test_full_depth();
        repeat (3) tick();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d expected reads never returned, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
